// File: rtl/md_sched_pkg.sv
// ---------------------------------------------------------------------------
// md_defs : shared definitions for the multiply/divide sequencer.
//
// Holds the 4-bit MD operation encodings driven by the decoder and the
// sequencer state encoding. md_sched and md_arith import it with
// "import md_defs::*".
//
// Optional feature macro: MD_SCHED_MADD_EN. The MADD/MADDU/MSUB/MSUBU
// encodings are always defined here. They are only acted upon when the
// macro is defined.
// ---------------------------------------------------------------------------
package md_defs;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NOP   = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_t;

  // True for the two divide encodings. These select the longer latency.
  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_arith.sv
// ---------------------------------------------------------------------------
// md_arith : purely combinational datapath for the multiply/divide sequencer.
//
// Produces the full 2*WIDTH-bit HI:LO result for the operation presented at
// the start edge, plus decode flags the sequencer needs to schedule it.
//
// Ports:
//   i_op        operation code (md_defs encoding)
//   i_rs, i_rt  operands (rs = dividend / multiplicand)
//   o_result    {hi, lo} result; for divides {remainder, quotient}
//   o_div_zero  divide op with a zero divisor (the result must be discarded)
//   o_long_op   op needs the multi-cycle sequencer
//   o_is_div    op uses the divide latency
//   o_accum     (MD_SCHED_MADD_EN only) result is accumulated into HI:LO
//   o_sub       (MD_SCHED_MADD_EN only) accumulate by subtraction
//
// Optional feature macro: MD_SCHED_MADD_EN adds the multiply-accumulate ops.
// ---------------------------------------------------------------------------
module md_arith
  import md_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0]    i_rs,
  input  logic [WIDTH-1:0]    i_rt,
  output logic [2*WIDTH-1:0]  o_result,
  output logic                o_div_zero,
  output logic                o_long_op,
`ifdef MD_SCHED_MADD_EN
  output logic                o_accum,
  output logic                o_sub,
`endif
  output logic                o_is_div
);

  logic signed [2*WIDTH-1:0] w_sprod;
  logic        [2*WIDTH-1:0] w_uprod;
  logic        [WIDTH-1:0]   w_divisor;
  logic signed [WIDTH-1:0]   w_squot;
  logic signed [WIDTH-1:0]   w_srem;
  logic        [WIDTH-1:0]   w_uquot;
  logic        [WIDTH-1:0]   w_urem;
  logic                      w_rt_zero;

  // Both products are formed at double width so no sign or carry bits are
  // lost. The signed one sign-extends its operands first.
  assign w_sprod = $signed({{WIDTH{i_rs[WIDTH-1]}}, i_rs}) *
                   $signed({{WIDTH{i_rt[WIDTH-1]}}, i_rt});
  assign w_uprod = {{WIDTH{1'b0}}, i_rs} * {{WIDTH{1'b0}}, i_rt};

  // A zero divisor is replaced by one so the dividers never produce X.
  // The flag makes the sequencer throw the result away anyway.
  assign w_rt_zero = (i_rt == '0);
  assign w_divisor = w_rt_zero ? WIDTH'(1) : i_rt;

  // Signed / and % truncate toward zero, so the remainder takes the sign of
  // the dividend.
  assign w_squot = $signed(i_rs) / $signed(w_divisor);
  assign w_srem  = $signed(i_rs) % $signed(w_divisor);
  assign w_uquot = i_rs / w_divisor;
  assign w_urem  = i_rs % w_divisor;

  assign o_is_div = md_is_div(i_op);

  always_comb begin
    o_result   = '0;
    o_div_zero = 1'b0;
    o_long_op  = 1'b0;
`ifdef MD_SCHED_MADD_EN
    o_accum    = 1'b0;
    o_sub      = 1'b0;
`endif
    case (i_op)
      MD_MULT: begin
        o_result  = w_sprod;
        o_long_op = 1'b1;
      end
      MD_MULTU: begin
        o_result  = w_uprod;
        o_long_op = 1'b1;
      end
      MD_DIV: begin
        o_result   = {w_srem, w_squot};
        o_div_zero = w_rt_zero;
        o_long_op  = 1'b1;
      end
      MD_DIVU: begin
        o_result   = {w_urem, w_uquot};
        o_div_zero = w_rt_zero;
        o_long_op  = 1'b1;
      end
`ifdef MD_SCHED_MADD_EN
      MD_MADD: begin
        o_result  = w_sprod;
        o_long_op = 1'b1;
        o_accum   = 1'b1;
      end
      MD_MADDU: begin
        o_result  = w_uprod;
        o_long_op = 1'b1;
        o_accum   = 1'b1;
      end
      MD_MSUB: begin
        o_result  = w_sprod;
        o_long_op = 1'b1;
        o_accum   = 1'b1;
        o_sub     = 1'b1;
      end
      MD_MSUBU: begin
        o_result  = w_uprod;
        o_long_op = 1'b1;
        o_accum   = 1'b1;
        o_sub     = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched : multiply/divide sequencer for the P6 pipeline, E stage.
//
// Accepts one HI/LO operation per start pulse. It models the fixed
// multi-cycle latency with a down-counter and owns the architectural HI/LO
// registers. The hazard unit uses busy to stall MD instructions in D.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-low reset
//   start   E-stage MD instruction valid this cycle
//   op      operation code (md_defs encoding)
//   rs_val  forwarded GPR[rs]
//   rt_val  forwarded GPR[rt]
//   busy    long operation in flight
//   done    one-cycle pulse in the last busy cycle
//   hi, lo  HI / LO registers
//
// Optional feature macro: MD_SCHED_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
// These accumulate into HI:LO using the HI:LO value present at completion.
// ---------------------------------------------------------------------------
module md_sched
  import md_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;
  logic [WIDTH-1:0]       r_pend_hi;
  logic [WIDTH-1:0]       r_pend_lo;
  logic                   r_pend_dz;
`ifdef MD_SCHED_MADD_EN
  logic                   r_pend_acc;
  logic                   r_pend_sub;
  logic                   w_accum;
  logic                   w_sub;
`endif

  logic [2*WIDTH-1:0]     w_result;
  logic                   w_div_zero;
  logic                   w_long_op;
  logic                   w_is_div;
  logic [CNT_W-1:0]       w_cycles;

  md_arith #(
    .WIDTH      (WIDTH)
  ) u_arith (
    .i_op       (op),
    .i_rs       (rs_val),
    .i_rt       (rt_val),
    .o_result   (w_result),
    .o_div_zero (w_div_zero),
    .o_long_op  (w_long_op),
`ifdef MD_SCHED_MADD_EN
    .o_accum    (w_accum),
    .o_sub      (w_sub),
`endif
    .o_is_div   (w_is_div)
  );

  assign w_cycles = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // The FSM, counter, pending result and HI/LO all live in one block.
  // done is registered so it equals (cnt == 1) during the last busy cycle.
  // It is set directly at the start edge when the latency is one cycle.
  // In RUN, start is ignored because the hazard unit never issues one there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_pend_hi  <= '0;
      r_pend_lo  <= '0;
      r_pend_dz  <= 1'b0;
`ifdef MD_SCHED_MADD_EN
      r_pend_acc <= 1'b0;
      r_pend_sub <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_long_op) begin
              r_state    <= S_RUN;
              r_busy     <= 1'b1;
              r_cnt      <= w_cycles;
              r_done     <= (w_cycles == CNT_W'(1));
              r_pend_hi  <= w_result[2*WIDTH-1:WIDTH];
              r_pend_lo  <= w_result[WIDTH-1:0];
              r_pend_dz  <= w_div_zero;
`ifdef MD_SCHED_MADD_EN
              r_pend_acc <= w_accum;
              r_pend_sub <= w_sub;
`endif
            end else if (op == MD_MTHI) begin
              r_hi <= rs_val;
            end else if (op == MD_MTLO) begin
              r_lo <= rs_val;
            end
          end
        end
        S_RUN: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            // A divide by zero still costs full latency but leaves HI/LO alone.
            if (!r_pend_dz) begin
`ifdef MD_SCHED_MADD_EN
              if (r_pend_acc && r_pend_sub) begin
                {r_hi, r_lo} <= {r_hi, r_lo} - {r_pend_hi, r_pend_lo};
              end else if (r_pend_acc) begin
                {r_hi, r_lo} <= {r_hi, r_lo} + {r_pend_hi, r_pend_lo};
              end else begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
              end
`else
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
`endif
            end
          end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(2));
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_sched.sv
// ---------------------------------------------------------------------------
// tb_md_sched : directed self-checking bench for md_sched.
//
// Inputs are driven just after the falling edge. Outputs are sampled 1 time
// unit after the rising edge. Expected values are hand-computed constants.
// Build with +define+MD_SCHED_MADD_EN to exercise the accumulate ops.
// ---------------------------------------------------------------------------
module tb_md_sched;
  import md_defs::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int passCount;
  int checkCount;

  md_sched #(
    .WIDTH       (32),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Present one op for a single rising edge. The task returns 1 unit after that edge.
  task automatic applyStimulus(input logic [3:0] opc, input logic [31:0] rs,
                               input logic [31:0] rt);
    @(negedge clk);
    start  = 1'b1;
    op     = opc;
    rs_val = rs;
    rt_val = rt;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op     = MD_NOP;
  endtask

  // Walk the n busy cycles after a start edge. Then check that busy and done
  // are both low again. The loop is bounded by n.
  task automatic checkBusyWindow(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
      checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, (k == n)});
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done_end"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    reset  = 1'b0;
    start  = 1'b0;
    op     = MD_NOP;
    rs_val = '0;
    rt_val = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // MULT -3 * 7 = -21
    applyStimulus(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    checkBusyWindow("mult", 5);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFEB);

    // DIVU 100 / 7 = 14 remainder 2
    applyStimulus(MD_DIVU, 32'd100, 32'd7);
    checkBusyWindow("divu", 10);
    checkOutput("divu_hi", hi, 32'd2);
    checkOutput("divu_lo", lo, 32'd14);

    // DIV 7 / -2 = -3 remainder 1
    applyStimulus(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    checkBusyWindow("div_pos", 10);
    checkOutput("div_pos_hi", hi, 32'd1);
    checkOutput("div_pos_lo", lo, 32'hFFFF_FFFD);

    // DIV -7 / 2 = -3 remainder -1
    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    checkBusyWindow("div", 10);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);

    // MTHI in IDLE: immediate update, no busy
    applyStimulus(MD_MTHI, 32'h1234_5678, 32'd0);
    checkOutput("mthi_hi", hi, 32'h1234_5678);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    checkOutput("mthi_done", {31'd0, done}, 32'd0);

    // Divide by zero: full latency, HI/LO unchanged
    applyStimulus(MD_DIV, 32'd55, 32'd0);
    checkBusyWindow("divz", 10);
    checkOutput("divz_hi", hi, 32'h1234_5678);
    checkOutput("divz_lo", lo, 32'hFFFF_FFFD);

    // Undefined op: no effect
    applyStimulus(4'd15, 32'hDEAD_BEEF, 32'd3);
    checkOutput("undef_busy", {31'd0, busy}, 32'd0);
    checkOutput("undef_hi", hi, 32'h1234_5678);
    checkOutput("undef_lo", lo, 32'hFFFF_FFFD);

    // MULTU 0x10000 * 0x10000 = 2^32
    applyStimulus(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
    checkBusyWindow("multu", 5);
    checkOutput("multu_hi", hi, 32'd1);
    checkOutput("multu_lo", lo, 32'd0);

    // MULTU max*max, aborted by async reset in busy cycle 3
    applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("abort_discard_hi", hi, 32'd0);
    checkOutput("abort_discard_busy", {31'd0, busy}, 32'd0);

    // MTLO after reset release
    applyStimulus(MD_MTLO, 32'd5, 32'd0);
    checkOutput("mtlo_lo", lo, 32'd5);
    checkOutput("mtlo_hi", hi, 32'd0);

    // MADDU 1*1 on HI:LO = 0:FFFFFFFF
    applyStimulus(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
    applyStimulus(MD_MADDU, 32'd1, 32'd1);
`ifdef MD_SCHED_MADD_EN
    checkBusyWindow("maddu", 5);
    checkOutput("maddu_hi", hi, 32'd1);
    checkOutput("maddu_lo", lo, 32'd0);
    // MSUB 1*1 returns to 0:FFFFFFFF
    applyStimulus(MD_MSUB, 32'd1, 32'd1);
    checkBusyWindow("msub", 5);
    checkOutput("msub_hi", hi, 32'd0);
    checkOutput("msub_lo", lo, 32'hFFFF_FFFF);
`else
    checkOutput("maddu_nop_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("maddu_nop_busy_late", {31'd0, busy}, 32'd0);
    checkOutput("maddu_nop_hi", hi, 32'd0);
    checkOutput("maddu_nop_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
